// File: rtl/bcd_display_pkg.sv
// Shared constants for the multiplexed BCD display scanner: segment patterns
// ({g,f,e,d,c,b,a}, active low), slot indices and the buffered display value.
package bcd_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam logic [1:0] SLOT_UNI = 2'd0;
  localparam logic [1:0] SLOT_DEZ = 2'd1;
  localparam logic [1:0] SLOT_CEN = 2'd2;
  localparam logic [1:0] SLOT_SGN = 2'd3;

  typedef struct packed {
    logic [3:0] cen;
    logic [3:0] dez;
    logic [3:0] uni;
    logic       neg;
  } bcd_value_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment decoder: BCD code plus blank/minus overrides to an
// active-low segment pattern. Codes 10..15 show "E" as an error indicator.
module seg7_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_ERR;
    if (minus_i) begin
      seg_n_o = SEG_MINUS;
    end else if (blank_i) begin
      seg_n_o = SEG_BLANK;
    end else begin
      case (code_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// 4-digit multiplexed common-anode display driver (sign, hundreds, tens, units)
// with frame-boundary double buffering, leading-zero blanking and a guard gap.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic       negative,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  GUARD_CYC  = PW'(GUARD);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  bcd_value_t    cap_q, cap_d;
  bcd_value_t    disp_q, disp_d;
  logic          pending_q, pending_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [3:0]    an_n_q, an_n_d;

  logic          slot_end;
  logic          frame_end;
  logic          in_guard;
  bcd_value_t    in_value;
  logic [3:0]    dig_code;
  logic          dig_blank;
  logic          dig_minus;
  logic [6:0]    dig_seg;

  assign slot_end   = (presc_q == PRESC_LAST);
  assign frame_end  = slot_end && (slot_q == SLOT_SGN);
  assign in_guard   = (presc_q < GUARD_CYC);
  assign frame_tick = frame_end;

  assign in_value.cen = centena;
  assign in_value.dez = dezena;
  assign in_value.uni = unidade;
  assign in_value.neg = negative;

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    slot_d  = slot_end ? slot_q + 2'd1 : slot_q;
  end

  // A load landing on the frame boundary bypasses the capture register so it
  // is shown from the very next frame without waiting a full extra frame.
  always_comb begin
    cap_d     = cap_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load) begin
      cap_d     = in_value;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_d = in_value;
      end else if (pending_q) begin
        disp_d = cap_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    dig_code  = disp_q.uni;
    dig_blank = 1'b0;
    dig_minus = 1'b0;
    case (slot_q)
      SLOT_UNI: dig_code = disp_q.uni;
      SLOT_DEZ: begin
        dig_code  = disp_q.dez;
        dig_blank = (disp_q.cen == 4'd0) && (disp_q.dez == 4'd0);
      end
      SLOT_CEN: begin
        dig_code  = disp_q.cen;
        dig_blank = (disp_q.cen == 4'd0);
      end
      default: begin
        dig_code  = 4'd0;
        dig_minus = disp_q.neg;
        dig_blank = ~disp_q.neg;
      end
    endcase
  end

  seg7_decoder u_dec (
    .code_i  (dig_code),
    .blank_i (dig_blank),
    .minus_i (dig_minus),
    .seg_n_o (dig_seg)
  );

  always_comb begin
    an_n_d  = in_guard ? 4'hF : ~(4'b0001 << slot_q);
    seg_n_d = in_guard ? SEG_BLANK : dig_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      slot_q    <= SLOT_UNI;
      cap_q     <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_n_q   <= SEG_BLANK;
      an_n_q    <= 4'hF;
    end else begin
      presc_q   <= presc_d;
      slot_q    <= slot_d;
      cap_q     <= cap_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_n_q   <= seg_n_d;
      an_n_q    <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule
